// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Brief    : MA-stage data-memory controller. Provides a ready/valid request
//            handshake, a configurable read latency, byte/half/word lane
//            access and sign/zero extension on loads.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_width,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         c_AW       = $clog2(DEPTH_WORDS);
    localparam logic [29:0] c_DEPTH   = 30'(DEPTH_WORDS);
    // WAIT exits when the counter is zero, so it starts two below LATENCY.
    localparam logic [1:0] c_CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    localparam logic [1:0] c_W_BYTE = 2'b00;
    localparam logic [1:0] c_W_HALF = 2'b01;
    localparam logic [1:0] c_W_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [0:DEPTH_WORDS-1];

    logic [31:0]     w_off;
    logic [29:0]     w_widx;
    logic [c_AW-1:0] w_idx;
    logic            w_unused_off;
    logic            w_oor;
    logic            w_misal;
    logic            w_illegal;
    logic            w_err;
    logic            w_hs;
    logic            w_wr_en;
    logic [31:0]     w_word;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata_sh;
    logic [7:0]      w_lane_b;
    logic [15:0]     w_lane_h;
    logic [31:0]     w_ld_data;

    // ------------------------------------------------------------------
    // Address decode and error classification
    // ------------------------------------------------------------------
    assign w_off        = req_addr - BASE_ADDR;
    assign w_widx       = w_off[31:2];
    assign w_unused_off = ^w_off[1:0];
    assign w_idx        = w_widx[c_AW-1:0];
    assign w_oor        = (req_addr < BASE_ADDR) || (w_widx >= c_DEPTH);

    assign w_misal   = ((req_width == c_W_HALF) && req_addr[0]) ||
                       ((req_width == c_W_WORD) && (req_addr[1:0] != 2'b00));
    assign w_illegal = (req_width == 2'b11);
    assign w_err     = w_oor || w_misal || w_illegal;

    assign w_hs    = req_valid && req_ready && !rst;
    assign w_wr_en = w_hs && req_we && !w_err;

    assign req_ready  = (r_state != S_WAIT);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = resp_valid ? r_rdata : 32'h0;
    assign resp_err   = resp_valid && r_err;

    // ------------------------------------------------------------------
    // Store lane steering
    // ------------------------------------------------------------------
    always_comb begin
        w_be       = 4'b0000;
        w_wdata_sh = req_wdata;
        case (req_width)
            c_W_BYTE: begin
                w_be       = 4'b0001 << req_addr[1:0];
                w_wdata_sh = {4{req_wdata[7:0]}};
            end
            c_W_HALF: begin
                w_be       = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_sh = {2{req_wdata[15:0]}};
            end
            c_W_WORD: begin
                w_be       = 4'b1111;
                w_wdata_sh = req_wdata;
            end
            default: begin
                w_be       = 4'b0000;
                w_wdata_sh = req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load lane selection and extension (array read at acceptance)
    // ------------------------------------------------------------------
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_lane_b = w_word[7:0];
        case (req_addr[1:0])
            2'd0:    w_lane_b = w_word[7:0];
            2'd1:    w_lane_b = w_word[15:8];
            2'd2:    w_lane_b = w_word[23:16];
            default: w_lane_b = w_word[31:24];
        endcase
        w_lane_h  = req_addr[1] ? w_word[31:16] : w_word[15:0];
        w_ld_data = 32'h0;
        if (!req_we && !w_err) begin
            case (req_width)
                c_W_BYTE: w_ld_data = {{24{~req_unsigned & w_lane_b[7]}}, w_lane_b};
                c_W_HALF: w_ld_data = {{16{~req_unsigned & w_lane_h[15]}}, w_lane_h};
                c_W_WORD: w_ld_data = w_word;
                default:  w_ld_data = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Request/response FSM; one request outstanding at most
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_hs) begin
                        r_rdata <= w_ld_data;
                        r_err   <= w_err;
                        if (LATENCY == 1) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 2'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Brief    : Directed self-checking bench for dmem_ctrl at LATENCY=1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        v1, we1, uns1, ready1, rv1, err1;
    logic [31:0] a1, wd1, rd1;
    logic [1:0]  w1;

    logic        v3, we3, uns3, ready3, rv3, err3;
    logic [31:0] a3, wd3, rd3;
    logic [1:0]  w3;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] vals [4];

    dmem_ctrl #(.BASE_ADDR(32'h10010000), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(ready1), .req_we(we1),
        .req_addr(a1), .req_width(w1), .req_unsigned(uns1), .req_wdata(wd1),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1)
    );

    dmem_ctrl #(.BASE_ADDR(32'h10010000), .DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(ready3), .req_we(we3),
        .req_addr(a3), .req_width(w3), .req_unsigned(uns3), .req_wdata(wd3),
        .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive at a negedge, check the LATENCY=1 response at the next negedge.
    task automatic req1(input logic we, input logic [31:0] addr, input logic [1:0] width,
                        input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
        v1 = 1'b1; we1 = we; a1 = addr; w1 = width; uns1 = uns; wd1 = wdata;
        check({tag, ":rdy"}, 32'(ready1), 32'd1);
        @(negedge clk);
        check({tag, ":rv"},  32'(rv1),  32'd1);
        check({tag, ":rd"},  rd1,       exp_rd);
        check({tag, ":err"}, 32'(err1), 32'(exp_err));
    endtask

    task automatic idle1();
        v1 = 1'b0;
        @(negedge clk);
        check("idle1:rv", 32'(rv1), 32'd0);
    endtask

    task automatic req3(input logic we, input logic [31:0] addr, input logic [1:0] width,
                        input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
        v3 = 1'b1; we3 = we; a3 = addr; w3 = width; uns3 = uns; wd3 = wdata;
        check({tag, ":rdy"}, 32'(ready3), 32'd1);
        @(negedge clk);
        v3 = 1'b0;
        repeat (2) begin
            check({tag, ":wait_rdy"}, 32'(ready3), 32'd0);
            check({tag, ":wait_rv"},  32'(rv3),    32'd0);
            @(negedge clk);
        end
        check({tag, ":rv"},  32'(rv3),  32'd1);
        check({tag, ":rd"},  rd3,       exp_rd);
        check({tag, ":err"}, 32'(err3), 32'(exp_err));
        @(negedge clk);
        check({tag, ":rv_off"}, 32'(rv3), 32'd0);
    endtask

    // Four word requests with req_valid held high throughout.
    task automatic b2b3(input logic we, input string tag);
        for (int k = 0; k < 4; k++) begin
            v3 = 1'b1; we3 = we; a3 = 32'h10010100 + 32'(4 * k);
            w3 = 2'b10; uns3 = 1'b0; wd3 = vals[k];
            check({tag, ":rdy"}, 32'(ready3), 32'd1);
            if (k > 0) begin
                check({tag, ":rv"}, 32'(rv3), 32'd1);
                check({tag, ":rd"}, rd3, we ? 32'h0 : vals[k-1]);
            end else begin
                check({tag, ":rv0"}, 32'(rv3), 32'd0);
            end
            repeat (2) begin
                @(negedge clk);
                check({tag, ":wait_rdy"}, 32'(ready3), 32'd0);
                check({tag, ":wait_rv"},  32'(rv3),    32'd0);
            end
            @(negedge clk);
        end
        v3 = 1'b0;
        check({tag, ":rv_last"}, 32'(rv3), 32'd1);
        check({tag, ":rd_last"}, rd3, we ? 32'h0 : vals[3]);
        @(negedge clk);
        check({tag, ":rv_off"},  32'(rv3),    32'd0);
        check({tag, ":rdy_off"}, 32'(ready3), 32'd1);
    endtask

    initial begin
        vals[0] = 32'h01010101; vals[1] = 32'h20202020;
        vals[2] = 32'h33003300; vals[3] = 32'h4567ABCD;
        rst = 1'b1;
        v1 = 0; we1 = 0; a1 = 0; w1 = 0; uns1 = 0; wd1 = 0;
        v3 = 0; we3 = 0; a3 = 0; w3 = 0; uns3 = 0; wd3 = 0;

        repeat (2) @(negedge clk);
        check("rst:rv",  32'(rv1),  32'd0);
        check("rst:rd",  rd1,       32'd0);
        check("rst:err", 32'(err1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst:rdy", 32'(ready1), 32'd1);

        // ---------------- LATENCY = 1 ----------------
        req1(1, 32'h10010008, 2'b10, 0, 32'hDEADBEEF, 32'h0,        0, "st_w08");
        req1(0, 32'h10010008, 2'b10, 0, 32'h0,        32'hDEADBEEF, 0, "ld_w08");
        req1(1, 32'h10010009, 2'b00, 0, 32'h00000012, 32'h0,        0, "st_b09");
        req1(0, 32'h1001000B, 2'b00, 0, 32'h0,        32'hFFFFFFDE, 0, "ld_bs0B");
        req1(0, 32'h1001000B, 2'b00, 1, 32'h0,        32'h000000DE, 0, "ld_bu0B");
        req1(0, 32'h10010008, 2'b01, 0, 32'h0,        32'h000012EF, 0, "ld_hs08");
        req1(0, 32'h10010008, 2'b10, 0, 32'h0,        32'hDEAD12EF, 0, "ld_w08b");
        req1(0, 32'h1001000A, 2'b01, 0, 32'h0,        32'hFFFFDEAD, 0, "ld_hs0A");
        req1(0, 32'h1001000A, 2'b01, 1, 32'h0,        32'h0000DEAD, 0, "ld_hu0A");
        req1(1, 32'h1001000A, 2'b01, 0, 32'h00007777, 32'h0,        0, "st_h0A");
        req1(0, 32'h10010008, 2'b10, 0, 32'h0,        32'h777712EF, 0, "ld_w08c");
        idle1();

        req1(1, 32'h10010000, 2'b10, 0, 32'h11223344, 32'h0,        0, "st_w00");
        req1(0, 32'h10010002, 2'b10, 0, 32'h0,        32'h0,        1, "mis_ldw");
        req1(1, 32'h10010001, 2'b01, 0, 32'h0000FFFF, 32'h0,        1, "mis_sth");
        req1(1, 32'h10010000, 2'b11, 0, 32'h99999999, 32'h0,        1, "ill_st");
        req1(0, 32'h10010000, 2'b11, 0, 32'h0,        32'h0,        1, "ill_ld");
        req1(0, 32'h10010000, 2'b10, 0, 32'h0,        32'h11223344, 0, "ld_w00");
        req1(0, 32'h10011000, 2'b10, 0, 32'h0,        32'h0,        1, "oor_hi");
        req1(0, 32'h1000FFFC, 2'b10, 0, 32'h0,        32'h0,        1, "oor_lo");
        req1(1, 32'h10010FFC, 2'b10, 0, 32'hCAFEF00D, 32'h0,        0, "st_top");
        req1(0, 32'h10010FFC, 2'b10, 0, 32'h0,        32'hCAFEF00D, 0, "ld_top");
        idle1();

        // Store presented while reset is high must not be written.
        rst = 1'b1; v1 = 1'b1; we1 = 1'b1; a1 = 32'h10010000; w1 = 2'b10; wd1 = 32'h55555555;
        @(negedge clk);
        check("rst_st:rv", 32'(rv1), 32'd0);
        rst = 1'b0; v1 = 1'b0;
        @(negedge clk);
        req1(0, 32'h10010000, 2'b10, 0, 32'h0, 32'h11223344, 0, "rst_st:ld");
        idle1();

        // ---------------- LATENCY = 3 ----------------
        b2b3(1'b1, "b2b_st");
        b2b3(1'b0, "b2b_ld");
        req3(0, 32'h10010002, 2'b10, 0, 32'h0, 32'h0, 1, "l3_mis");

        // Store accepted, then reset while it sits in WAIT.
        v3 = 1'b1; we3 = 1'b1; a3 = 32'h10010040; w3 = 2'b10; wd3 = 32'h0BADF00D;
        @(negedge clk);
        v3 = 1'b0;
        check("rst_wait_st:rdy", 32'(ready3), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_wait_st:rv", 32'(rv3), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("rst_wait_st:rv_after",  32'(rv3),    32'd0);
            check("rst_wait_st:rdy_after", 32'(ready3), 32'd1);
        end

        // Load accepted, then reset while it sits in WAIT.
        v3 = 1'b1; we3 = 1'b0; a3 = 32'h10010100; w3 = 2'b10; uns3 = 1'b0;
        @(negedge clk);
        v3 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_wait_ld:rv", 32'(rv3), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("rst_wait_ld:rv_after",  32'(rv3),    32'd0);
            check("rst_wait_ld:rdy_after", 32'(ready3), 32'd1);
        end

        req3(0, 32'h10010040, 2'b10, 0, 32'h0, 32'h0BADF00D, 0, "rst_wait_st:ld");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
